dcpu_bus_arbiter: RTL

- Shares the single 16-bit-data / 32-bit-address memory bus between two masters.
- Master 0 is the dcpu core; master 1 is a DMA/debug port.
- Round-robin arbitration, grant held for a whole bus cycle (while the master holds cyc), and a per-transfer ack timeout that returns an error strobe so a missing slave cannot hang the CPU fetch state machine.

---
 rtl/dcpu_bus_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dcpu_bus_arbiter.sv
// Two-master round-robin arbiter for the dcpu 16-bit data / 32-bit address memory bus.
// A master keeps the grant while it holds cyc. A strobe that is never acked ends with an err pulse.
module dcpu_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_m0_cyc,
  input  logic [1:0]  i_m0_stb,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [15:0] i_m0_dat,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  input  logic        i_m1_cyc,
  input  logic [1:0]  i_m1_stb,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [15:0] i_m1_dat,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [15:0] o_m_dat,
  output logic        o_s_cyc,
  output logic [1:0]  o_s_stb,
  output logic        o_s_we,
  output logic [31:0] o_s_addr,
  output logic [15:0] o_s_dat,
  input  logic        i_s_ack,
  input  logic [15:0] i_s_dat,
  output logic [1:0]  o_grant
);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;  // 1 = m1 owned the bus most recently
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [1:0]      grant;
  logic            strobing;
  logic            ack_any;
  logic            err;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        // On a tie, m0 wins only if m1 was the last owner
        if (i_m0_cyc && (!i_m1_cyc || last_q)) state_d = StGrant0;
        else if (i_m1_cyc)                     state_d = StGrant1;
      end
      StGrant0: begin
        if (!i_m0_cyc) begin
          last_d  = 1'b0;
          state_d = i_m1_cyc ? StGrant1 : StIdle;
        end
      end
      StGrant1: begin
        if (!i_m1_cyc) begin
          last_d  = 1'b1;
          state_d = i_m0_cyc ? StGrant0 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant    = 2'b00;
    o_s_cyc  = 1'b0;
    o_s_stb  = 2'b00;
    o_s_we   = 1'b0;
    o_s_addr = i_m0_addr;
    o_s_dat  = i_m0_dat;
    unique case (state_q)
      StGrant0: begin
        grant   = 2'b01;
        o_s_cyc = i_m0_cyc;
        o_s_stb = i_m0_cyc ? i_m0_stb : 2'b00;
        o_s_we  = i_m0_we;
      end
      StGrant1: begin
        grant    = 2'b10;
        o_s_cyc  = i_m1_cyc;
        o_s_stb  = i_m1_cyc ? i_m1_stb : 2'b00;
        o_s_we   = i_m1_we;
        o_s_addr = i_m1_addr;
        o_s_dat  = i_m1_dat;
      end
      default: ;
    endcase
  end

  assign o_grant  = grant;
  assign o_m_dat  = i_s_dat;
  assign o_m0_ack = i_s_ack & grant[0] & (i_m0_stb != 2'b00);
  assign o_m1_ack = i_s_ack & grant[1] & (i_m1_stb != 2'b00);
  assign ack_any  = o_m0_ack | o_m1_ack;

  // An ack in the terminal cycle takes priority over the timeout
  assign strobing = (o_s_stb != 2'b00);
  assign err      = strobing & ~ack_any & (cnt_q == TO_W'(TIMEOUT - 1));
  assign o_m0_err = err & grant[0];
  assign o_m1_err = err & grant[1];

  always_comb begin
    cnt_d = cnt_q + TO_W'(1);
    if (!strobing || ack_any || err) cnt_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
